// File: rtl/nmcu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : nmcu_mem_responder
// Purpose  : Behavioural main-memory responder for the nmcu mem_req_t /
//            mem_resp_t protocol. Takes one request at a time and models a
//            fixed access latency. Reads return a burst of one word per cycle.
//            Writes return a single acknowledge beat.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_WORDS   storage depth in 32-bit words (power of two)
//   LATENCY     cycles from request accept to first response beat (>= 1)
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_i        in   74  {valid, write_en, addr[31:0], wdata[31:0], len[7:0]}
//   req_ready_o  out  1   request accepted this cycle if req_i valid
//   resp_o       out  66  {valid, addr[31:0], rdata[31:0], hit}
//   busy_o       out  1   transaction in flight
//   err_o        out  1   out-of-range beat flag (NMCU_MEM_BOUNDS_CHECK_EN only)
// Build option
//   NMCU_MEM_BOUNDS_CHECK_EN  when defined, word indices are not wrapped.
//                             Out-of-range beats raise err_o. Out-of-range
//                             reads return 32'hDEAD_BEEF. Out-of-range writes
//                             are dropped.
// Memory contents are not reset. Preload the memory through write
// transactions.
// ============================================================================
module nmcu_mem_responder #(
    parameter int MEM_WORDS = 16384,
    parameter int LATENCY   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [73:0] req_i,
    output logic        req_ready_o,
    output logic [65:0] resp_o,
    output logic        busy_o
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
    ,
    output logic        err_o
`endif
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // lat_cnt only has to reach LATENCY-1
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BEAT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               req_valid;
    logic               req_write;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [7:0]         req_len;

    logic               is_write;
    logic [31:0]        cur_addr;
    logic [31:0]        wdata;
    logic [7:0]         beats_left;
    logic [LAT_W-1:0]   lat_cnt;

    logic               accept;
    logic               issue;
    logic               mem_we;
    logic               out_of_range;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        beat_data;

    logic [31:0]        mem [MEM_WORDS];

    assign req_valid = req_i[73];
    assign req_write = req_i[72];
    assign req_addr  = req_i[71:40];
    assign req_wdata = req_i[39:8];
    assign req_len   = req_i[7:0];

    // Ready is a pure decode of state. It is gated by rst_n so the
    // responder never advertises ready while held in reset.
    assign req_ready_o = (state == S_IDLE) && rst_n;
    assign busy_o      = (state != S_IDLE);
    assign accept      = req_valid && req_ready_o;

    // The index takes the low word-address bits, so the default build
    // wraps modulo MEM_WORDS.
    assign idx = cur_addr[IDX_W+1:2];

`ifdef NMCU_MEM_BOUNDS_CHECK_EN
    assign out_of_range = |cur_addr[31:IDX_W+2];
`else
    assign out_of_range = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state decode. `issue` marks the edge that loads a beat into
    // resp_o. The last WAIT edge issues beat 0. Each BEAT edge then
    // issues the next beat while any remain. The BEAT edge after the
    // last beat clears resp_o and returns to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LAT_W'(LATENCY - 1)) begin
                    issue      = 1'b1;
                    state_next = S_BEAT;
                end
            end
            S_BEAT: begin
                if (beats_left != 8'd0) begin
                    issue = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        beat_data = is_write ? wdata : mem[idx];
        if (out_of_range && !is_write) begin
            beat_data = 32'hDEAD_BEEF;
        end
        mem_we = issue && is_write && !out_of_range;
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, latency counter, beat sequencing, and
    // the registered response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write   <= 1'b0;
            cur_addr   <= 32'd0;
            wdata      <= 32'd0;
            beats_left <= 8'd0;
            lat_cnt    <= '0;
            resp_o     <= 66'd0;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
            err_o      <= 1'b0;
`endif
        end else begin
            // Each beat is a single-cycle pulse. All fields return to 0
            // unless a beat is issued.
            resp_o <= 66'd0;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
            err_o  <= 1'b0;
`endif
            if (accept) begin
                is_write   <= req_write;
                cur_addr   <= req_addr;
                wdata      <= req_wdata;
                beats_left <= (req_write || req_len == 8'd0) ? 8'd1 : req_len;
                lat_cnt    <= '0;
            end
            if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (issue) begin
                resp_o     <= {1'b1, cur_addr, beat_data, 1'b0};
                cur_addr   <= cur_addr + 32'd4;
                beats_left <= beats_left - 8'd1;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
                err_o      <= out_of_range;
`endif
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nmcu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmcu_mem_responder
// Purpose  : Directed self-checking bench for nmcu_mem_responder
// Revision : 1.0  initial release
// ============================================================================
module tb_nmcu_mem_responder;

    localparam int MEM_WORDS = 16384;
    localparam int LATENCY   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [73:0] req = 74'd0;
    logic        req_ready;
    logic [65:0] resp;
    logic        busy;
    logic        err;

    int passed = 0;
    int total  = 0;

    // Beats captured by collect()
    int          nb;
    int          first_lat;
    bit          gap;
    logic [31:0] b_addr [16];
    logic [31:0] b_data [16];
    logic        b_hit  [16];
    logic        b_err  [16];

    always #5 clk = ~clk;

`ifdef NMCU_MEM_BOUNDS_CHECK_EN
    nmcu_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_ready_o(req_ready),
        .resp_o(resp), .busy_o(busy), .err_o(err)
    );
`else
    assign err = 1'b0;
    nmcu_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_ready_o(req_ready),
        .resp_o(resp), .busy_o(busy)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Present a request, check it is accepted on the next edge, then drop valid.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [7:0] len);
        req = {1'b1, we, addr, wd, len};
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req[73] = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Record response beats in the cycles after the accept edge. Stop at
    // the first idle cycle after a beat, or when the cycle bound runs out.
    task automatic collect(input int bound);
        int last;
        nb = 0; first_lat = 0; gap = 1'b0; last = 0;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk); #1;
            if (resp[65]) begin
                if (nb == 0) first_lat = k;
                else if (k != last + 1) gap = 1'b1;
                if (nb < 16) begin
                    b_addr[nb] = resp[64:33];
                    b_data[nb] = resp[32:1];
                    b_hit[nb]  = resp[0];
                    b_err[nb]  = err;
                end
                nb++;
                last = k;
            end else if (nb > 0) begin
                chk("resp_clear_after_burst", resp[31:0], 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int vcount;

        // ---- 1: reset with a pending request ----
        req = {1'b1, 1'b0, 32'h40, 32'h0, 8'd1};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_lo", resp[31:0], 32'd0);
        chk("rst_resp_hi", {30'd0, resp[65:64]}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        req = 74'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", {31'd0, req_ready}, 32'd1);

        // ---- 2: single write then read ----
        issue(1'b1, 32'h40, 32'hCAFE_0001, 8'd0);
        collect(20);
        chk("wr_lat", first_lat, LATENCY);
        chk("wr_nb", nb, 1);
        chk("wr_addr", b_addr[0], 32'h40);
        chk("wr_data", b_data[0], 32'hCAFE_0001);
        chk("wr_hit", {31'd0, b_hit[0]}, 32'd0);
        chk("wr_idle_busy", {31'd0, busy}, 32'd0);
        chk("wr_idle_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 32'h40, 32'h0, 8'd1);
        collect(20);
        chk("rd_lat", first_lat, LATENCY);
        chk("rd_nb", nb, 1);
        chk("rd_data", b_data[0], 32'hCAFE_0001);

        // ---- 3: preload words 0..7, then bursts ----
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 32'(4 * i), 32'h100 + 32'(i), 8'd3);
            collect(20);
            chk("pre_nb", nb, 1);
        end
        issue(1'b0, 32'h8, 32'h0, 8'd4);
        collect(30);
        chk("bu_lat", first_lat, LATENCY);
        chk("bu_nb", nb, 4);
        chk("bu_gap", {31'd0, gap}, 32'd0);
        chk("bu_a0", b_addr[0], 32'h08);
        chk("bu_a1", b_addr[1], 32'h0C);
        chk("bu_a2", b_addr[2], 32'h10);
        chk("bu_a3", b_addr[3], 32'h14);
        chk("bu_d0", b_data[0], 32'h102);
        chk("bu_d1", b_data[1], 32'h103);
        chk("bu_d2", b_data[2], 32'h104);
        chk("bu_d3", b_data[3], 32'h105);
        issue(1'b0, 32'h0, 32'h0, 8'd0);
        collect(30);
        chk("len0_nb", nb, 1);
        chk("len0_data", b_data[0], 32'h100);

        // ---- 4: requests while busy are ignored ----
        issue(1'b0, 32'h8, 32'h0, 8'd4);
        req = {1'b1, 1'b1, 32'h80, 32'h5555, 8'd0};
        collect(30);
        chk("bz_nb", nb, 4);
        chk("bz_lat", first_lat, LATENCY);
        chk("bz_d3", b_data[3], 32'h105);
        chk("bz_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req[73] = 1'b0;
        chk("bz_accept_busy", {31'd0, busy}, 32'd1);
        collect(20);
        chk("bz_ack_nb", nb, 1);
        chk("bz_ack_addr", b_addr[0], 32'h80);
        chk("bz_ack_lat", first_lat, LATENCY);
        issue(1'b0, 32'h80, 32'h0, 8'd1);
        collect(20);
        chk("bz_rd", b_data[0], 32'h5555);

        // ---- 5: word-index wrap / bounds ----
        issue(1'b1, 32'(4 * (MEM_WORDS - 1)), 32'hABCD_0000, 8'd0);
        collect(20);
        chk("wrap_wr_nb", nb, 1);
        issue(1'b0, 32'(4 * (MEM_WORDS - 1)), 32'h0, 8'd2);
        collect(30);
        chk("wrap_nb", nb, 2);
        chk("wrap_a0", b_addr[0], 32'h0000_FFFC);
        chk("wrap_a1", b_addr[1], 32'h0001_0000);
        chk("wrap_d0", b_data[0], 32'hABCD_0000);
        chk("wrap_e0", {31'd0, b_err[0]}, 32'd0);
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
        chk("wrap_d1", b_data[1], 32'hDEAD_BEEF);
        chk("wrap_e1", {31'd0, b_err[1]}, 32'd1);
`else
        chk("wrap_d1", b_data[1], 32'h100);
        chk("wrap_e1", {31'd0, b_err[1]}, 32'd0);
`endif

        // ---- 6: reset during a burst ----
        issue(1'b0, 32'h0, 32'h0, 8'd8);
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (resp[65]) vcount++;
            if (vcount == 3) break;
        end
        chk("mr_beat2_data", resp[32:1], 32'h102);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, resp[65]}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (resp[65]) vcount++;
        end
        chk("mr_no_residual", vcount, 0);
        chk("mr_idle", {31'd0, busy}, 32'd0);
        issue(1'b0, 32'h40, 32'h0, 8'd1);
        collect(20);
        chk("mr_keep_40", b_data[0], 32'hCAFE_0001);
        issue(1'b0, 32'h14, 32'h0, 8'd1);
        collect(20);
        chk("mr_keep_14", b_data[0], 32'h105);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
